// File: rtl/memrsp.sv
// Byte-wide memory responder: one request at a time, optional wait states, one-cycle ready pulse.
// Optional wait-state counter is compiled in with `define MEMRSP_WAIT_EN; otherwise every access takes WAIT=0 timing.
module memrsp #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int WAIT       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             ready,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (WAIT < 0 || WAIT > 15 || DEPTH_LOG2 > WIDTH || DEPTH_LOG2 < 1) begin : g_bad_params
        $error("memrsp: WAIT must be 0..15 and DEPTH_LOG2 must be 1..WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DEPTH_LOG2-1:0]   ladr_q;
    logic [WIDTH-1:0]        ldata_q;
    logic                    lwr_q;
    logic [WIDTH-1:0]        memdata_q;
    logic                    ready_q;
    logic                    busy_q;
    logic [WIDTH-1:0]        mem_q [DEPTH];

`ifdef MEMRSP_WAIT_EN
    localparam logic [3:0] WAIT_C = 4'(WAIT);
    logic [3:0]            cnt_q;
`endif

    logic                  req;
    logic                  idle;
    logic                  go_ack;
    logic [DEPTH_LOG2-1:0] acc_adr;
    logic [WIDTH-1:0]      acc_data;
    logic                  acc_wr;
    logic                  unused_adr_bits;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign unused_adr_bits = ^(adr >> DEPTH_LOG2);

    // With zero wait states the access happens on the IDLE edge itself, so the
    // live request fields are used instead of the latched copies.
    always_comb begin
        req      = memread | memwrite;
        idle     = (state_q == S_IDLE);
        acc_adr  = idle ? adr[DEPTH_LOG2-1:0] : ladr_q;
        acc_data = idle ? writedata : ldata_q;
        acc_wr   = idle ? memwrite : lwr_q;
`ifdef MEMRSP_WAIT_EN
        go_ack   = (idle && req && (WAIT_C == 4'd0)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd1));
`else
        go_ack   = idle && req;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ladr_q    <= '0;
            ldata_q   <= '0;
            lwr_q     <= 1'b0;
            memdata_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MEMRSP_WAIT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            ready_q <= go_ack;
            if (go_ack && !acc_wr) begin
                memdata_q <= mem_q[acc_adr];
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        ladr_q  <= adr[DEPTH_LOG2-1:0];
                        ldata_q <= writedata;
                        lwr_q   <= memwrite;
                        busy_q  <= 1'b1;
`ifdef MEMRSP_WAIT_EN
                        cnt_q   <= WAIT_C;
`endif
                        state_q <= go_ack ? S_ACK : S_WAIT;
                    end
                end
`ifdef MEMRSP_WAIT_EN
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACK;
                    end
                end
`endif
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The array has no reset; a reset on the ACK edge cancels the pending write.
    always_ff @(posedge clk) begin
        if (!reset && go_ack && acc_wr) begin
            mem_q[acc_adr] <= acc_data;
        end
    end

    assign memdata     = memdata_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_memrsp.sv
// Self-checking bench for memrsp: reset, vector table, fetch burst, reset mid-write, random traffic.
module tb_memrsp;

  localparam int TB_WAIT = 3;
`ifdef MEMRSP_WAIT_EN
  localparam int EFF_WAIT = TB_WAIT;
`else
  localparam int EFF_WAIT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] memdata;
  logic       ready;
  logic       busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  memrsp #(.WIDTH(8), .DEPTH_LOG2(6), .WAIT(TB_WAIT)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .memread     (memread),
    .memwrite    (memwrite),
    .adr         (adr),
    .writedata   (writedata),
    .memdata     (memdata),
    .ready       (ready),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] model_mem [64];
  logic [7:0] model_md;
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request/response; returns memdata seen with ready.
  task automatic access(input logic wr, input logic rd, input logic [7:0] a,
                        input logic [7:0] wd, input string name, output logic [7:0] rdata);
    int cyc;
    bit seen;
    bit busy_bad;
    if (wr) model_mem[a % 64] = wd;
    else    model_md = model_mem[a % 64];
    exp_q.push_back(model_md);
    memwrite  = wr;
    memread   = rd;
    adr       = a;
    writedata = wd;
    cyc = 0;
    seen = 0;
    busy_bad = 0;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      if (busy !== 1'b1) busy_bad = 1;
      if (ready === 1'b1) seen = 1;
    end
    rdata = memdata;
    check({name, " ready seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(EFF_WAIT + 1));
    check({name, " busy while active"}, 32'(busy_bad), 32'd0);
    check({name, " memdata"}, 32'(rdata), 32'(exp_q.pop_front()));
    memread  = 1'b0;
    memwrite = 1'b0;
    step();
    check({name, " ready drops"}, 32'(ready), 32'd0);
    check({name, " busy drops"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] exp_md;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] rdata;
    logic [7:0] burst_d [4];
    int cyc;
    bit seen;

    tbl[0] = '{1'b1, 1'b0, 8'h03, 8'h5A, 8'h00};  // write leaves memdata at reset value
    tbl[1] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h5A};
    tbl[2] = '{1'b1, 1'b0, 8'h45, 8'hC3, 8'h5A};  // aliases onto 0x05
    tbl[3] = '{1'b0, 1'b1, 8'h05, 8'h00, 8'hC3};
    tbl[4] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h5A};
    tbl[5] = '{1'b1, 1'b1, 8'h10, 8'h7E, 8'h5A};  // write wins, memdata held
    tbl[6] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h7E};
    tbl[7] = '{1'b0, 1'b1, 8'h85, 8'h00, 8'hC3};

    // reset state
    model_md = 8'h00;
    repeat (3) step();
    check("reset memdata", 32'(memdata), 32'h0);
    check("reset ready", 32'(ready), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset state", 32'(dbg_state), 32'h0);
    reset = 1'b0;
    step();

    // preload every location so the model is fully defined
    for (int i = 0; i < 64; i++)
      access(1'b1, 1'b0, 8'(i), 8'($urandom_range(0, 255)), "preload", rdata);

    for (int i = 0; i < 8; i++) begin
      access(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, $sformatf("vec%0d", i), rdata);
      check($sformatf("vec%0d table memdata", i), 32'(rdata), 32'(tbl[i].exp_md));
    end

    // fetch-style burst with memread held high
    burst_d[0] = 8'h11; burst_d[1] = 8'h22; burst_d[2] = 8'h33; burst_d[3] = 8'h44;
    for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 8'(i), burst_d[i], "burst preload", rdata);
    memread = 1'b1;
    adr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 40) begin
        step();
        cyc++;
        if (ready === 1'b1) seen = 1;
      end
      check($sformatf("burst%0d ready", k), 32'(seen), 32'd1);
      check($sformatf("burst%0d spacing", k), 32'(cyc), 32'(k == 0 ? EFF_WAIT + 1 : EFF_WAIT + 2));
      check($sformatf("burst%0d data", k), 32'(memdata), 32'(burst_d[k]));
      adr = 8'(k + 1);
    end
    memread = 1'b0;
    model_md = 8'h44;
    step();

    // reset mid-write: write lands only if its ACK edge precedes the reset edge
    access(1'b1, 1'b0, 8'h08, 8'h01, "rstw preload", rdata);
    memwrite = 1'b1;
    adr = 8'h08;
    writedata = 8'hFF;
    seen = 0;
    step();
    if (ready === 1'b1) seen = 1;
    step();
    if (ready === 1'b1) seen = 1;
    reset = 1'b1;
    memwrite = 1'b0;
    step();
    reset = 1'b0;
    if (EFF_WAIT <= 1) model_mem[8] = 8'hFF;
    model_md = 8'h00;
    check("rstw ready before reset", 32'(seen), 32'(EFF_WAIT <= 1));
    check("rstw ready after", 32'(ready), 32'h0);
    check("rstw busy after", 32'(busy), 32'h0);
    check("rstw memdata after", 32'(memdata), 32'h0);
    check("rstw state after", 32'(dbg_state), 32'h0);
    step();
    access(1'b0, 1'b1, 8'h08, 8'h00, "rstw readback", rdata);
    check("rstw readback value", 32'(rdata), 32'(EFF_WAIT <= 1 ? 8'hFF : 8'h01));

    // randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic wr;
      logic rd;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      access(wr, rd, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             $sformatf("rand%0d", i), rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
